word_count_unit: RTL and testbench

Word-count datapath of the DMA address generator: holds the word count register and the word counter, decodes the 3-bit instruction, and produces `word_cnt` and the look-ahead `next_word_cnt` consumed by the transfer-complete comparator. It also registers a sticky completion flag from that comparator's `done`. It sits beside the address counter, between the instruction/data bus and the done logic.

---
 rtl/word_count_unit_pkg.sv | 29 ++
 rtl/word_count_unit_if.sv | 30 +++
 rtl/word_count_unit_next.sv | 36 +++
 rtl/word_count_unit.sv | 62 ++++++
 tb/tb_word_count_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/word_count_unit_pkg.sv
// Shared instruction and control-mode encodings for the DMA word-count datapath.
package word_count_unit_pkg;

   localparam int unsigned DataLength = 16;

   typedef enum logic [2:0] {
      InstrWrcr   = 3'b000,
      InstrRdcr   = 3'b001,
      InstrRdwc   = 3'b010,
      InstrRdac   = 3'b011,
      InstrReinit = 3'b100,
      InstrLdaddr = 3'b101,
      InstrLdwc   = 3'b110,
      InstrEnct   = 3'b111
   } instr_e;

   typedef enum logic [1:0] {
      ModeWcDown  = 2'b00,
      ModeWcUp    = 2'b01,
      ModeAddrCmp = 2'b10,
      ModeFreeRun = 2'b11
   } mode_e;

   // Counter-clear modes start the word counter from zero on LDWC/REINIT.
   function automatic logic is_clear_mode(mode_e mode);
      return (mode == ModeWcUp) || (mode == ModeFreeRun);
   endfunction

endpackage

// File: rtl/word_count_unit_if.sv
// Bus-side signals of the word-count unit: instruction/data in, counts and readback out.
interface word_count_unit_if
   import word_count_unit_pkg::*;
#(
   parameter int unsigned DATA_LENGTH = DataLength
);

   instr_e                  instr;
   logic [DATA_LENGTH-1:0]  data_in;
   mode_e                   ctrl_mode;
   logic                    cinwc;
   logic                    done;
   logic [DATA_LENGTH-1:0]  word_cnt;
   logic [DATA_LENGTH-1:0]  word_counter;
   logic [DATA_LENGTH-1:0]  next_word_cnt;
   logic [DATA_LENGTH-1:0]  data_out;
   logic                    data_oe;
   logic                    done_flag;

   modport master (
      output instr, data_in, ctrl_mode, cinwc, done,
      input  word_cnt, word_counter, next_word_cnt, data_out, data_oe, done_flag
   );

   modport slave (
      input  instr, data_in, ctrl_mode, cinwc, done,
      output word_cnt, word_counter, next_word_cnt, data_out, data_oe, done_flag
   );

endinterface

// File: rtl/word_count_unit_next.sv
// Next-value mux of the word counter; feeds both the register and the look-ahead output.
module word_count_unit_next
   import word_count_unit_pkg::*;
#(
   parameter int unsigned DATA_LENGTH = DataLength
) (
   input  instr_e                 instr_i,
   input  mode_e                  mode_i,
   input  logic                   cinwc_i,
   input  logic [DATA_LENGTH-1:0] data_i,
   input  logic [DATA_LENGTH-1:0] word_cnt_i,
   input  logic [DATA_LENGTH-1:0] word_counter_i,
   output logic [DATA_LENGTH-1:0] next_o
);

   logic [DATA_LENGTH-1:0] step;
   assign step = DATA_LENGTH'(cinwc_i);

   always_comb begin
      next_o = word_counter_i;
      case (instr_i)
         InstrLdwc:   next_o = is_clear_mode(mode_i) ? '0 : data_i;
         InstrReinit: next_o = is_clear_mode(mode_i) ? '0 : word_cnt_i;
         InstrEnct: begin
            unique case (mode_i)
               ModeWcDown:            next_o = word_counter_i - step;
               ModeWcUp, ModeFreeRun: next_o = word_counter_i + step;
               // Counter carries the end address in this mode, so it must not move.
               ModeAddrCmp:           next_o = word_counter_i;
            endcase
         end
         default:     next_o = word_counter_i;
      endcase
   end

endmodule

// File: rtl/word_count_unit.sv
// Word count register, word counter and sticky completion flag of the DMA address generator.
module word_count_unit
   import word_count_unit_pkg::*;
#(
   parameter int unsigned DATA_LENGTH = DataLength
) (
   input  logic              clk,
   input  logic              rst_n,
   word_count_unit_if.slave  bus
);

   logic [DATA_LENGTH-1:0] word_cnt_q, word_cnt_d;
   logic [DATA_LENGTH-1:0] word_counter_q, word_counter_d;
   logic                   done_flag_q, done_flag_d;

   word_count_unit_next #(
      .DATA_LENGTH (DATA_LENGTH)
   ) u_next (
      .instr_i        (bus.instr),
      .mode_i         (bus.ctrl_mode),
      .cinwc_i        (bus.cinwc),
      .data_i         (bus.data_in),
      .word_cnt_i     (word_cnt_q),
      .word_counter_i (word_counter_q),
      .next_o         (word_counter_d)
   );

   always_comb begin
      word_cnt_d  = word_cnt_q;
      done_flag_d = done_flag_q;
      case (bus.instr)
         InstrLdwc: begin
            word_cnt_d  = bus.data_in;
            done_flag_d = 1'b0;
         end
         InstrReinit: done_flag_d = 1'b0;
         // done is judged on next_word_cnt, so the flag lands with that counter value.
         InstrEnct:   done_flag_d = done_flag_q | bus.done;
         default:     ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_q     <= '0;
         word_counter_q <= '0;
         done_flag_q    <= 1'b0;
      end else begin
         word_cnt_q     <= word_cnt_d;
         word_counter_q <= word_counter_d;
         done_flag_q    <= done_flag_d;
      end
   end

   assign bus.word_cnt      = word_cnt_q;
   assign bus.word_counter  = word_counter_q;
   assign bus.next_word_cnt = word_counter_d;
   assign bus.done_flag     = done_flag_q;
   assign bus.data_oe       = (bus.instr == InstrRdwc);
   assign bus.data_out      = bus.data_oe ? word_counter_q : '0;

endmodule

// File: tb/tb_word_count_unit.sv
// Directed bench for word_count_unit with a per-cycle reference model and literal checkpoints.
module tb_word_count_unit;
   import word_count_unit_pkg::*;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   logic        done_en;
   logic [15:0] done_tgt;

   word_count_unit_if #(.DATA_LENGTH(16)) ifc ();

   word_count_unit #(.DATA_LENGTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   // Stand-in transfer-complete comparator.
   assign ifc.done = done_en && (ifc.next_word_cnt == done_tgt);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural state kept as plain integers.
   int m_wc, m_ctr;
   bit m_flag;

   function automatic int model_next();
      int step;
      bit clear;
      clear = (ifc.ctrl_mode == ModeWcUp) || (ifc.ctrl_mode == ModeFreeRun);
      case (ifc.instr)
         InstrLdwc:   return clear ? 0 : int'(ifc.data_in);
         InstrReinit: return clear ? 0 : m_wc;
         InstrEnct: begin
            if (ifc.ctrl_mode == ModeAddrCmp) step = 0;
            else if (ifc.ctrl_mode == ModeWcDown) step = -int'(ifc.cinwc);
            else step = int'(ifc.cinwc);
            return (m_ctr + step + 65536) % 65536;
         end
         default:     return m_ctr;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wc   <= 0;
         m_ctr  <= 0;
         m_flag <= 1'b0;
      end else begin
         m_ctr <= model_next();
         if (ifc.instr == InstrLdwc) m_wc <= int'(ifc.data_in);
         if (ifc.instr == InstrLdwc || ifc.instr == InstrReinit) m_flag <= 1'b0;
         else if (ifc.instr == InstrEnct)
            m_flag <= m_flag | (done_en && (model_next() == int'(done_tgt)));
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cyc_word_cnt", 32'(ifc.word_cnt), 32'(m_wc));
         chk("cyc_word_counter", 32'(ifc.word_counter), 32'(m_ctr));
         chk("cyc_next_word_cnt", 32'(ifc.next_word_cnt), 32'(model_next()));
         chk("cyc_done_flag", 32'(ifc.done_flag), 32'(m_flag));
         chk("cyc_data_oe", 32'(ifc.data_oe), 32'(ifc.instr == InstrRdwc));
         chk("cyc_data_out", 32'(ifc.data_out),
             (ifc.instr == InstrRdwc) ? 32'(m_ctr) : 32'd0);
      end
   end

   task automatic op(input instr_e i, input logic [15:0] d, input logic c);
      ifc.instr   = i;
      ifc.data_in = d;
      ifc.cinwc   = c;
      @(posedge clk);
      #1;
   endtask

   logic [15:0] down_exp [4];
   logic        down_flag [4];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n         = 1'b0;
      ifc.instr     = InstrWrcr;
      ifc.data_in   = '0;
      ifc.ctrl_mode = ModeWcDown;
      ifc.cinwc     = 1'b0;
      done_en       = 1'b0;
      done_tgt      = '0;
      down_exp  = '{16'd2, 16'd1, 16'd0, 16'hFFFF};
      down_flag = '{1'b0, 1'b1, 1'b1, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_word_cnt", 32'(ifc.word_cnt), 32'd0);
      chk("rst_word_counter", 32'(ifc.word_counter), 32'd0);
      chk("rst_next", 32'(ifc.next_word_cnt), 32'd0);
      chk("rst_done_flag", 32'(ifc.done_flag), 32'd0);
      chk("rst_data_oe", 32'(ifc.data_oe), 32'd0);
      rst_n = 1'b1;

      // Mode 00 count-down through zero; flag lands when the counter reaches 1.
      done_en  = 1'b1;
      done_tgt = 16'd1;
      op(InstrLdwc, 16'd3, 1'b0);
      chk("dn_load_ctr", 32'(ifc.word_counter), 32'd3);
      chk("dn_load_wc", 32'(ifc.word_cnt), 32'd3);
      for (int k = 0; k < 4; k++) begin
         ifc.instr = InstrEnct;
         ifc.cinwc = 1'b1;
         #1;
         chk("dn_lookahead", 32'(ifc.next_word_cnt), 32'(down_exp[k]));
         op(InstrEnct, 16'd0, 1'b1);
         chk("dn_ctr", 32'(ifc.word_counter), 32'(down_exp[k]));
         chk("dn_flag", 32'(ifc.done_flag), 32'(down_flag[k]));
         chk("model_dn_ctr", 32'(m_ctr), 32'(down_exp[k]));
      end

      // Asynchronous reset in the middle of a count.
      done_en = 1'b0;
      op(InstrLdwc, 16'd5, 1'b0);
      chk("mid_ctr", 32'(ifc.word_counter), 32'd5);
      ifc.instr = InstrWrcr;
      #1 rst_n = 1'b0;
      #1;
      chk("arst_word_cnt", 32'(ifc.word_cnt), 32'd0);
      chk("arst_word_counter", 32'(ifc.word_counter), 32'd0);
      chk("arst_next", 32'(ifc.next_word_cnt), 32'd0);
      chk("arst_done_flag", 32'(ifc.done_flag), 32'd0);
      chk("arst_data_out", 32'(ifc.data_out), 32'd0);
      chk("arst_data_oe", 32'(ifc.data_oe), 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Mode 01 count-up, then REINIT restarts from zero and clears the flag.
      ifc.ctrl_mode = ModeWcUp;
      done_en  = 1'b1;
      done_tgt = 16'd3;
      op(InstrLdwc, 16'd4, 1'b0);
      chk("up_load_wc", 32'(ifc.word_cnt), 32'd4);
      chk("up_load_ctr", 32'(ifc.word_counter), 32'd0);
      repeat (4) op(InstrEnct, 16'd0, 1'b1);
      chk("up_ctr", 32'(ifc.word_counter), 32'd4);
      chk("up_flag", 32'(ifc.done_flag), 32'd1);
      op(InstrReinit, 16'd0, 1'b0);
      chk("reinit_ctr", 32'(ifc.word_counter), 32'd0);
      chk("reinit_wc", 32'(ifc.word_cnt), 32'd4);
      chk("reinit_flag", 32'(ifc.done_flag), 32'd0);

      // ENCT with cinwc low holds, but done still sets the flag.
      ifc.ctrl_mode = ModeWcDown;
      done_tgt = 16'd9;
      op(InstrLdwc, 16'd9, 1'b0);
      op(InstrEnct, 16'd0, 1'b0);
      chk("hold_ctr", 32'(ifc.word_counter), 32'd9);
      chk("hold_flag", 32'(ifc.done_flag), 32'd1);

      // Mode 10 never moves the counter.
      done_en = 1'b0;
      ifc.ctrl_mode = ModeAddrCmp;
      op(InstrLdwc, 16'h1234, 1'b0);
      repeat (10) op(InstrEnct, 16'd0, 1'b1);
      chk("addr_ctr", 32'(ifc.word_counter), 32'h1234);
      chk("addr_wc", 32'(ifc.word_cnt), 32'h1234);

      // Wrap at all-ones and readback.
      ifc.ctrl_mode = ModeFreeRun;
      op(InstrLdwc, 16'd7, 1'b0);
      chk("fr_load_ctr", 32'(ifc.word_counter), 32'd0);
      chk("fr_load_wc", 32'(ifc.word_cnt), 32'd7);
      ifc.ctrl_mode = ModeWcDown;
      op(InstrLdwc, 16'd0, 1'b0);
      op(InstrEnct, 16'd0, 1'b1);
      chk("force_ffff", 32'(ifc.word_counter), 32'hFFFF);
      ifc.ctrl_mode = ModeFreeRun;
      ifc.instr = InstrRdwc;
      #1;
      chk("rd_oe", 32'(ifc.data_oe), 32'd1);
      chk("rd_out_ffff", 32'(ifc.data_out), 32'hFFFF);
      op(InstrRdwc, 16'd0, 1'b0);
      op(InstrEnct, 16'd0, 1'b1);
      chk("wrap_zero", 32'(ifc.word_counter), 32'd0);
      chk("model_wrap", 32'(m_ctr), 32'd0);
      op(InstrEnct, 16'd0, 1'b1);
      ifc.instr = InstrRdac;
      #1;
      chk("nrd_oe", 32'(ifc.data_oe), 32'd0);
      chk("nrd_out", 32'(ifc.data_out), 32'd0);
      ifc.instr = InstrRdwc;
      #1;
      chk("rd_out_one", 32'(ifc.data_out), 32'd1);
      op(InstrWrcr, 16'd0, 1'b0);

      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
